// File: rtl/rot8_pkg.sv
// rot8 sequencer shared types: opcodes, register modes, FSM states.
// Imported by rot8_reg and rot8_sequencer.
package rot8_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ROTR = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] ROR1  = 2'b01;
  localparam logic [1:0] ROR2  = 2'b10;
  localparam logic [1:0] SLOAD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/rot8_reg.sv
// 8-bit mode-muxed register: 00 load pi, 01 ror1, 10 ror2, 11 load sln.
// Ports: clk, rst (async active-low), mode, pi, sln -> po.
module rot8_reg
  import rot8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] pi,
  input  logic [7:0] sln,
  output logic [7:0] po
);

  logic [7:0] d;

  always_comb begin
    d = po;
    unique case (mode)
      HOLD:  d = pi;
      ROR1:  d = {po[0], po[7:1]};
      ROR2:  d = {po[1:0], po[7:2]};
      SLOAD: d = sln;
      default: d = po;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) po <= 8'h00;
    else      po <= d;
  end

endmodule

// File: rtl/rot8_sequencer.sv
// Command sequencer: breaks LOAD/ROTR/ROTL into ror2/ror1 register steps.
// Ports: cmd_* handshake in, data_out/rot_mode/busy/done out, rst active-low.
module rot8_sequencer
  import rot8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_amt,
  output logic [7:0] data_out,
  output logic [1:0] rot_mode,
  output logic       busy,
  output logic       done
);

  state_e     state;
  logic [2:0] rem;
  logic       ld_pend;
  logic [7:0] cap_data;
  logic       last;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == EXEC);

  // Mode is a pure decode of registered state.
  always_comb begin
    rot_mode = HOLD;
    if (state == EXEC) begin
      unique case (1'b1)
        ld_pend:          rot_mode = SLOAD;
        (rem >= 3'd2):    rot_mode = ROR2;
        (rem == 3'd1):    rot_mode = ROR1;
        default:          rot_mode = HOLD;
      endcase
    end
  end

  // Final step: load, ror1, hold, or a ror2 that empties rem.
  assign last = ld_pend || (rem <= 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= 3'd0;
      ld_pend  <= 1'b0;
      cap_data <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cap_data <= cmd_data;
            unique case (op_e'(cmd_op))
              OP_NOP: ;
              OP_LOAD: begin
                state   <= EXEC;
                rem     <= 3'd0;
                ld_pend <= 1'b1;
              end
              OP_ROTR: begin
                state <= EXEC;
                rem   <= cmd_amt;
              end
              OP_ROTL: begin
                state <= EXEC;
                rem   <= 3'd0 - cmd_amt;
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          ld_pend <= 1'b0;
          if (!ld_pend) begin
            if (rem >= 3'd2) rem <= rem - 3'd2;
            else             rem <= 3'd0;
          end
          if (last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rot8_reg u_reg (
    .clk  (clk),
    .rst  (rst),
    .mode (rot_mode),
    .pi   (data_out),
    .sln  (cap_data),
    .po   (data_out)
  );

endmodule

// File: tb/tb_rot8_sequencer.sv
// Directed bench for rot8_sequencer with immediate-assertion checks.
// Inputs driven after posedge, outputs sampled on negedge.
module tb_rot8_sequencer;
  import rot8_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_amt;
  logic [7:0] data_out;
  logic [1:0] rot_mode;
  logic       busy;
  logic       done;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  rot8_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_amt   (cmd_amt),
    .data_out  (data_out),
    .rot_mode  (rot_mode),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; accepted at the next posedge.
  task automatic send(input logic [1:0] op,
                      input logic [7:0] d,
                      input logic [2:0] a);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_amt   = a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic load(input logic [7:0] d);
    send(OP_LOAD, d, 3'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;
    cmd_amt   = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  data_out,        8'h00);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_busy",  {7'd0, busy},      8'd0);
    chk("rst_done",  {7'd0, done},      8'd0);
    chk("rst_mode",  {6'd0, rot_mode},  8'd0);
    rst = 1'b1;

    // LOAD 0xA5
    send(OP_LOAD, 8'hA5, 3'd0);
    @(negedge clk);
    chk("ld_mode",  {6'd0, rot_mode}, 8'd3);
    chk("ld_busy",  {7'd0, busy},     8'd1);
    chk("ld_done0", {7'd0, done},     8'd0);
    @(negedge clk);
    chk("ld_data",  data_out,          8'hA5);
    chk("ld_done1", {7'd0, done},      8'd1);
    chk("ld_idle",  {7'd0, busy},      8'd0);
    chk("ld_ready", {7'd0, cmd_ready}, 8'd1);
    @(negedge clk);
    chk("ld_done2", {7'd0, done},      8'd0);

    // ROTR 3 on 0x01
    load(8'h01);
    send(OP_ROTR, 8'hFF, 3'd3);
    @(negedge clk);
    chk("r3_m1", {6'd0, rot_mode}, 8'd2);
    @(negedge clk);
    chk("r3_d1", data_out,         8'h40);
    chk("r3_m2", {6'd0, rot_mode}, 8'd1);
    chk("r3_dn0", {7'd0, done},    8'd0);
    @(negedge clk);
    chk("r3_d2", data_out,         8'h20);
    chk("r3_dn", {7'd0, done},     8'd1);
    chk("r3_bz", {7'd0, busy},     8'd0);

    // ROTL 1 on 0x81 -> four steps
    load(8'h81);
    send(OP_ROTL, 8'h00, 3'd1);
    @(negedge clk);
    chk("l1_m1", {6'd0, rot_mode}, 8'd2);
    @(negedge clk);
    chk("l1_d1", data_out,         8'h60);
    chk("l1_m2", {6'd0, rot_mode}, 8'd2);
    @(negedge clk);
    chk("l1_d2", data_out,         8'h18);
    chk("l1_m3", {6'd0, rot_mode}, 8'd2);
    @(negedge clk);
    chk("l1_d3", data_out,         8'h06);
    chk("l1_m4", {6'd0, rot_mode}, 8'd1);
    chk("l1_bz", {7'd0, busy},     8'd1);
    @(negedge clk);
    chk("l1_d4", data_out,         8'h03);
    chk("l1_dn", {7'd0, done},     8'd1);

    // ROTR 0: a single hold cycle
    load(8'h3C);
    send(OP_ROTR, 8'h00, 3'd0);
    @(negedge clk);
    chk("r0_mode", {6'd0, rot_mode}, 8'd0);
    chk("r0_busy", {7'd0, busy},     8'd1);
    @(negedge clk);
    chk("r0_data", data_out,         8'h3C);
    chk("r0_done", {7'd0, done},     8'd1);

    // ROTR 6 with valid held, reset after first step
    load(8'hF0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_ROTR;
    cmd_data  = 8'h00;
    cmd_amt   = 3'd6;
    @(negedge clk);
    chk("h_mode",  {6'd0, rot_mode},  8'd2);
    chk("h_ready", {7'd0, cmd_ready}, 8'd0);
    @(negedge clk);
    chk("h_data",  data_out,          8'h3C);
    chk("h_busy",  {7'd0, busy},      8'd1);
    chk("h_rdy2",  {7'd0, cmd_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("mr_data",  data_out,          8'h00);
    chk("mr_busy",  {7'd0, busy},      8'd0);
    chk("mr_ready", {7'd0, cmd_ready}, 8'd1);
    chk("mr_mode",  {6'd0, rot_mode},  8'd0);
    chk("mr_done",  {7'd0, done},      8'd0);
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Back-to-back: LOAD 0x11 accepted during done pulse
    send(OP_LOAD, 8'h22, 3'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bb_done", {7'd0, done},      8'd1);
    chk("bb_rdy",  {7'd0, cmd_ready}, 8'd1);
    chk("bb_d0",   data_out,          8'h22);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h11;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    @(negedge clk);
    chk("bb_mode", {6'd0, rot_mode}, 8'd3);
    chk("bb_busy", {7'd0, busy},     8'd1);
    chk("bb_dn0",  {7'd0, done},     8'd0);
    @(negedge clk);
    chk("bb_data", data_out,         8'h11);
    chk("bb_dn1",  {7'd0, done},     8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rot8_sequencer.md
# rot8_sequencer

Command-driven controller for the 8-bit multi-mode register (mode 00 parallel load, 01 rotate-right-1, 10 rotate-right-2, 11 load from `sln`). It accepts LOAD / ROTR / ROTL commands over a valid/ready handshake. Each rotate is broken into a cycle-by-cycle sequence of rotate-by-2 and rotate-by-1 steps, and the block drives the register's mode select and feedback path. It owns one instance of the register and is the only agent allowed to change its contents.

## Interface
- Parameters: none. Width is fixed at 8 by the register's mux topology.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: the block can accept a command this cycle.
- `cmd_op` input 2: command opcode.
  - 00 NOP
  - 01 LOAD
  - 10 ROTR
  - 11 ROTL
- `cmd_data` input 8: load value, used by LOAD only.
- `cmd_amt` input 3: rotate amount 0–7, used by ROTR and ROTL only.
- `data_out` output 8: current register contents (`PO`).
- `rot_mode` output 2: mode applied to the register this cycle.
- `busy` output 1: a command is executing.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- **Handshake**
  - A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` is 1 exactly in state IDLE.
  - `cmd_op`, `cmd_data` and `cmd_amt` are captured at acceptance. Later changes on these inputs are ignored.
- **Register feedback**
  - `PI` is tied to `data_out`, so mode 00 means hold.
  - `sln` is driven from the captured data.
- **FSM states**
  - IDLE: `rot_mode` is 00 (hold), `busy` is 0.
    - On accepting NOP: go to IDLE. No `done` pulse.
    - On accepting LOAD: go to EXEC with remaining steps `rem`=0 and a pending load.
    - On accepting ROTR: go to EXEC with `rem`=`cmd_amt`.
    - On accepting ROTL: go to EXEC with `rem`=(8−`cmd_amt`) mod 8.
  - EXEC: `busy` is 1. The per-cycle action is chosen in this priority order:
    - Pending load: `rot_mode`=11. The register takes `cmd_data`.
    - `rem` ≥ 2: `rot_mode`=10, then `rem` −= 2.
    - `rem` = 1: `rot_mode`=01, then `rem` = 0.
    - `rem` = 0 with no load (zero-amount rotate): `rot_mode`=00 for one hold cycle.
  - EXEC exits to IDLE on the edge that applies its final action. `done` goes to 1 for exactly the following cycle.
- **Step count**
  - S = 1 for LOAD.
  - S = floor(n/2) + (n mod 2) for a rotate by n, with a minimum of 1 (n=0 gives one hold cycle).
- **Rotate sense**
  - Rotate-right-1 gives `d[i]`=`q[i+1]` and `d[7]`=`q[0]`.
  - Rotate-right-2 wraps bits 0 and 1 into bits 6 and 7.
- **Back-to-back commands:** `cmd_ready` is 1 in the cycle `done` is high, so a new command can be accepted then. Sustained throughput is one command per S cycles.
- **Held `cmd_valid` while busy:** not accepted and not queued. The requester must hold it until `cmd_ready` is 1.
- **Reset at any time, including mid-command**
  - Outputs: `data_out`=0x00, `rot_mode`=00, `busy`=0, `done`=0, `cmd_ready`=1.
  - State returns to IDLE and the in-flight command is discarded.

## Timing
- Accepted at edge k → EXEC occupies cycles k+1 … k+S.
- `data_out` is final after edge k+S. `done`=1 during cycle k+S+1 only.
- `rot_mode` and `busy` are registered-state decodes. `cmd_ready` is combinational from state only, never from `cmd_valid`.
- No combinational path from any input to any output.

## Structure
- Package `rot8_pkg` holds:
  - the opcode enum: NOP, LOAD, ROTR, ROTL;
  - mode constants: HOLD=00, ROR1=01, ROR2=10, SLOAD=11;
  - the FSM state enum: IDLE, EXEC.
- Sub-module `rot8_reg`: the 8-bit mode-muxed register (four-input mux per bit plus a DFF with asynchronous active-low reset). It is instantiated once.
- The sequencer FSM, the `rem` counter and the capture registers live in the top module.

## Test plan
1. **Reset:** assert `rst`=0 mid-run.
   - Required: `data_out`=0x00, `cmd_ready`=1, `busy`=0, `done`=0, `rot_mode`=00.
2. **LOAD:** LOAD 0xA5 accepted at edge k.
   - Required: `rot_mode`=11 in cycle k+1, `data_out`=0xA5 after k+1, `done` high in cycle k+2 only.
3. **ROTR 3:** LOAD 0x01, then ROTR 3.
   - Required: `rot_mode` sequence 10, 01; `data_out` 0x40 then 0x20; `done` after 2 EXEC cycles.
4. **ROTL 1:** LOAD 0x81, then ROTL 1 (treated as ROTR 7).
   - Required: modes 10, 10, 10, 01; final `data_out`=0x03; 4 EXEC cycles.
5. **ROTR 0:** LOAD 0x3C, then ROTR 0.
   - Required: one cycle with `rot_mode`=00, `data_out` stays 0x3C, `done` pulses.
6. **Reset mid-op and back-to-back:**
   - LOAD 0xF0, then ROTR 6 with `cmd_valid` held high throughout. Required: no second accept while `busy`=1.
   - Pull `rst` low after the first ROR2 step. Required: `data_out`=0x00, IDLE.
   - After release, issue LOAD 0x11 in the same cycle as a `done` pulse. Required: it is accepted with no bubble.
